// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shift-right arbiter: id-width helper and default result layout.
package shift_arb_pkg;

    // Keeps id ports at least one bit wide even for degenerate requester counts.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DefN = 16;
    localparam int unsigned DefS = 4;
    localparam int unsigned DefR = 4;

    typedef struct packed {
        logic [DefN-1:0]                  data;
        logic                             sticky;
        logic [clog2_safe(DefR)-1:0]      src;
    } shift_res_t;

endpackage

// File: rtl/shift_right.sv
// Combinational logarithmic barrel shifter: logical right shift with zero fill at the MSB.
module shift_right #(
    parameter int unsigned N = 16,
    parameter int unsigned S = 4
) (
    input  logic [N-1:0] data,
    input  logic [S-1:0] shamt,
    output logic [N-1:0] result
);

    always_comb begin
        result = data;
        for (int unsigned k = 0; k < S; k++) begin
            if (shamt[k]) begin
                // Stages at or beyond the word width flush everything out.
                if ((64'd1 << k) >= 64'(N)) begin
                    result = '0;
                end else begin
                    result = result >> (32'd1 << k);
                end
            end
        end
    end

endmodule

// File: rtl/shift_right_arbiter.sv
// Round-robin sharing of one shift_right datapath between R valid/ready requesters,
// registering the shifted word, sticky bit and source id on a single output channel.
module shift_right_arbiter
    import shift_arb_pkg::*;
#(
    parameter int unsigned N = DefN,
    parameter int unsigned S = DefS,
    parameter int unsigned R = DefR,
    localparam int unsigned IDW = clog2_safe(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_data,
    input  logic [R*S-1:0] req_shamt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic           out_sticky,
    output logic [IDW-1:0] out_src
);

    typedef struct packed {
        logic [N-1:0]   data;
        logic           sticky;
        logic [IDW-1:0] src;
    } res_t;

    res_t           res_q, res_d;
    logic           out_valid_q, out_valid_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic           load_en, any_valid, xfer;
    logic [IDW-1:0] winner;
    logic [N-1:0]   sel_data, shifted;
    logic [S-1:0]   sel_shamt;
    logic           sel_sticky;

    // Returns {found, index} of the first valid requester at or after ptr, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [R-1:0] valid,
                                             input logic [IDW-1:0] ptr);
        int unsigned idx;
        logic [IDW:0] pick;
        pick = '0;
        for (int unsigned off = 0; off < R; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= R) idx = idx - R;
            if (!pick[IDW] && valid[IDW'(idx)]) pick = {1'b1, IDW'(idx)};
        end
        return pick;
    endfunction

    assign load_en             = !out_valid_q || out_ready;
    assign {any_valid, winner} = rr_pick(req_valid, rr_ptr_q);
    assign xfer                = load_en && any_valid;

    always_comb begin
        req_ready = '0;
        sel_data  = '0;
        sel_shamt = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (winner == IDW'(i)) begin
                sel_data  = req_data[i*N +: N];
                sel_shamt = req_shamt[i*S +: S];
                req_ready[i] = xfer;
            end
        end
    end

    shift_right #(
        .N(N),
        .S(S)
    ) u_shift_right (
        .data  (sel_data),
        .shamt (sel_shamt),
        .result(shifted)
    );

    always_comb begin
        sel_sticky = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i < 32'(sel_shamt)) sel_sticky = sel_sticky | sel_data[i];
        end
    end

    always_comb begin
        res_d       = res_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            res_d       = '{data: shifted, sticky: sel_sticky, src: winner};
            out_valid_d = 1'b1;
            rr_ptr_d    = (winner == IDW'(R - 1)) ? '0 : winner + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = res_q.data;
    assign out_sticky = res_q.sticky;
    assign out_src    = res_q.src;

endmodule
